cpu_bus_responder: RTL and testbench

- Memory-side responder for the 8-bit CPU data bus.
- Decodes the CPU's addr/read/write/dout and returns read data on the CPU's din.
- Contains a 240-byte RAM plus memory-mapped peripherals: LED register, prescaled timer with compare, 4-entry TX byte FIFO drained over a valid/ready port.
- Sits beside the CPU in the top level; the CPU's data-bus outputs connect straight to it.

---
 rtl/cpu_bus_responder.sv | 225 ++++++++++++++++++++++
 tb/tb_cpu_bus_responder.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_bus_responder.sv
// cpu_bus_responder: memory-side responder for the 8-bit CPU data bus.
// Provides 240 bytes of asynchronous-read RAM plus an LED register, a
// prescaled timer with a sticky compare flag, and a small TX byte FIFO
// drained through a valid/ready port.
//
// TX port handshake: tx_valid is high whenever the FIFO holds at least one
// byte and tx_data then shows the oldest byte; a byte leaves the FIFO on
// every rising clk edge where tx_valid and tx_ready are both high. tx_valid
// never depends combinationally on tx_ready.
//
// Address map:
//   0x00-0xEF  RAM (read/write)
//   0xF0       LEDS (read/write)
//   0xF1       TIMER count (read; write loads count and clears prescaler)
//   0xF2       CMP (read/write)
//   0xF3       STATUS (read-only; reading clears match and overflow)
//              {1'b0, count[2:0], overflow, empty, full, match}
//   0xF4       TX_DATA (write pushes into FIFO; reads return 0)
//   0xF5-0xFF  reads return 0, writes ignored
module cpu_bus_responder #(
  parameter int PRESCALE   = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] cpu_addr,
  input  logic       cpu_read,
  input  logic       cpu_write,
  input  logic [7:0] cpu_dout,
  output logic [7:0] cpu_din,
  output logic [7:0] leds,
  output logic       timer_match,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready
);

  // Widths derived from the parameters; a PRESCALE or FIFO_DEPTH of 1
  // still gets a 1-bit register so every vector has a legal width.
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);
  localparam logic [AW-1:0] PTR_LAST   = AW'(FIFO_DEPTH - 1);
  localparam logic [CW-1:0] CNT_FULL   = CW'(FIFO_DEPTH);

  localparam logic [7:0] ADDR_LEDS   = 8'hF0;
  localparam logic [7:0] ADDR_TIMER  = 8'hF1;
  localparam logic [7:0] ADDR_CMP    = 8'hF2;
  localparam logic [7:0] ADDR_STATUS = 8'hF3;
  localparam logic [7:0] ADDR_TX     = 8'hF4;

  // Storage and state
  logic [7:0]    r_ram [0:239];
  logic [7:0]    r_leds;
  logic [PW-1:0] r_presc;
  logic [7:0]    r_count;
  logic [7:0]    r_cmp;
  logic          r_match;
  logic          r_ovf;
  logic [7:0]    r_fifo [FIFO_DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [CW-1:0] r_cnt;

  // Bus decode
  logic       w_is_ram;
  logic       w_wr_ram;
  logic       w_wr_leds;
  logic       w_wr_timer;
  logic       w_wr_cmp;
  logic       w_wr_tx;
  logic       w_rd_status;

  // Timer helpers
  logic       w_tick;
  logic [7:0] w_count_inc;
  logic       w_match_set;

  // FIFO helpers
  logic       w_full;
  logic       w_empty;
  logic       w_pop;
  logic       w_push_ok;
  logic       w_push_drop;
  logic [2:0] w_cnt3;
  logic [7:0] w_status;
  logic [7:0] w_din;

  assign w_is_ram    = (cpu_addr < ADDR_LEDS);
  assign w_wr_ram    = cpu_write && w_is_ram;
  assign w_wr_leds   = cpu_write && (cpu_addr == ADDR_LEDS);
  assign w_wr_timer  = cpu_write && (cpu_addr == ADDR_TIMER);
  assign w_wr_cmp    = cpu_write && (cpu_addr == ADDR_CMP);
  assign w_wr_tx     = cpu_write && (cpu_addr == ADDR_TX);
  assign w_rd_status = cpu_read  && (cpu_addr == ADDR_STATUS);

  // The increment that lands on CMP raises match, unless a CPU load of the
  // count in the same cycle overrides the tick.
  assign w_tick      = (r_presc == PRESC_LAST);
  assign w_count_inc = r_count + 8'd1;
  assign w_match_set = w_tick && !w_wr_timer && (w_count_inc == r_cmp);

  // A push into a full FIFO is only accepted when a pop frees a slot on the
  // same edge; otherwise the byte is dropped and overflow is flagged.
  assign w_full      = (r_cnt == CNT_FULL);
  assign w_empty     = (r_cnt == '0);
  assign w_pop       = !w_empty && tx_ready;
  assign w_push_ok   = w_wr_tx && (!w_full || w_pop);
  assign w_push_drop = w_wr_tx && w_full && !w_pop;

  assign w_cnt3   = 3'(r_cnt);
  assign w_status = {1'b0, w_cnt3, r_ovf, w_empty, w_full, r_match};

  assign leds        = r_leds;
  assign timer_match = r_match;
  assign tx_valid    = !w_empty;
  assign tx_data     = r_fifo[r_rptr];
  assign cpu_din     = w_din;

  // Zero-wait read mux; shows pre-write values when read and write collide.
  always_comb begin
    w_din = 8'h00;
    if (cpu_read) begin
      if (w_is_ram) begin
        w_din = r_ram[cpu_addr];
      end else begin
        case (cpu_addr)
          ADDR_LEDS:   w_din = r_leds;
          ADDR_TIMER:  w_din = r_count;
          ADDR_CMP:    w_din = r_cmp;
          ADDR_STATUS: w_din = w_status;
          default:     w_din = 8'h00;
        endcase
      end
    end
  end

  // RAM write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (!rst && w_wr_ram) begin
      r_ram[cpu_addr] <= cpu_dout;
    end
  end

  // LED register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_leds <= 8'h00;
    end else if (w_wr_leds) begin
      r_leds <= cpu_dout;
    end
  end

  // Prescaler, timer count and compare register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_presc <= '0;
      r_count <= 8'h00;
      r_cmp   <= 8'hFF;
    end else begin
      if (w_wr_timer) begin
        r_count <= cpu_dout;
        r_presc <= '0;
      end else begin
        r_presc <= w_tick ? '0 : r_presc + PW'(1);
        if (w_tick) begin
          r_count <= w_count_inc;
        end
      end
      if (w_wr_cmp) begin
        r_cmp <= cpu_dout;
      end
    end
  end

  // Sticky status flags; a set event beats the read-to-clear of STATUS.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_match <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      if (w_match_set) begin
        r_match <= 1'b1;
      end else if (w_rd_status) begin
        r_match <= 1'b0;
      end
      if (w_push_drop) begin
        r_ovf <= 1'b1;
      end else if (w_rd_status) begin
        r_ovf <= 1'b0;
      end
    end
  end

  // FIFO storage; no reset needed because the pointers define validity.
  always_ff @(posedge clk) begin
    if (w_push_ok) begin
      r_fifo[r_wptr] <= cpu_dout;
    end
  end

  // FIFO pointers and occupancy count.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_push_ok) begin
        r_wptr <= (r_wptr == PTR_LAST) ? '0 : r_wptr + AW'(1);
      end
      if (w_pop) begin
        r_rptr <= (r_rptr == PTR_LAST) ? '0 : r_rptr + AW'(1);
      end
      case ({w_push_ok, w_pop})
        2'b10:   r_cnt <= r_cnt + CW'(1);
        2'b01:   r_cnt <= r_cnt - CW'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_bus_responder.sv
// tb_cpu_bus_responder: directed scenarios followed by randomized bus
// traffic, every cycle compared against a behavioural model of the
// responder (byte array, integer timer, byte queue for the FIFO).
module tb_cpu_bus_responder;

  localparam int PRESCALE = 4;
  localparam int DEPTH    = 4;

  // ---------------- clock / reset / DUT ----------------
  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] cpu_addr;
  logic       cpu_read;
  logic       cpu_write;
  logic [7:0] cpu_dout;
  logic [7:0] cpu_din;
  logic [7:0] leds;
  logic       timer_match;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  always #5 clk = ~clk;

  cpu_bus_responder #(.PRESCALE(PRESCALE), .FIFO_DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .cpu_addr    (cpu_addr),
    .cpu_read    (cpu_read),
    .cpu_write   (cpu_write),
    .cpu_dout    (cpu_dout),
    .cpu_din     (cpu_din),
    .leds        (leds),
    .timer_match (timer_match),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready)
  );

  // ---------------- scoreboard / checking ----------------
  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [7:0] m_ram [256];
  int         m_leds;
  int         m_count;
  int         m_cmp;
  int         m_presc;
  bit         m_match;
  bit         m_ovf;
  logic [7:0] exp_q [$];

  // Values sampled from the DUT in the most recent step.
  logic [7:0] obs_din;
  logic [7:0] obs_tx_data;
  logic       obs_tx_valid;
  logic       obs_match;
  bit         cur_rdy;

  task automatic model_reset();
    m_leds  = 0;
    m_count = 0;
    m_cmp   = 255;
    m_presc = 0;
    m_match = 0;
    m_ovf   = 0;
    exp_q.delete();
  endtask

  function automatic logic [7:0] model_read(input logic [7:0] a);
    int st;
    if (a < 8'hF0) return m_ram[a];
    case (a)
      8'hF0: return 8'(m_leds);
      8'hF1: return 8'(m_count);
      8'hF2: return 8'(m_cmp);
      8'hF3: begin
        st = int'(m_match) + 2 * int'(exp_q.size() == DEPTH) + 4 * int'(exp_q.size() == 0)
           + 8 * int'(m_ovf) + 16 * exp_q.size();
        return 8'(st);
      end
      default: return 8'h00;
    endcase
  endfunction

  task automatic model_update(input bit r, input logic [7:0] a, input bit rd, input bit wr,
                              input logic [7:0] d, input bit rdy);
    bit tick;
    bit n_match;
    bit n_ovf;
    bit pop;
    bit push;
    int size0;
    if (r) begin
      model_reset();
      return;
    end
    tick    = (m_presc == PRESCALE - 1);
    n_match = m_match;
    n_ovf   = m_ovf;
    if (rd && a == 8'hF3) begin
      n_match = 0;
      n_ovf   = 0;
    end
    if (wr && a == 8'hF1) begin
      m_count = d;
      m_presc = 0;
    end else begin
      m_presc = tick ? 0 : m_presc + 1;
      if (tick) begin
        m_count = (m_count + 1) % 256;
        if (m_count == m_cmp) n_match = 1;
      end
    end
    size0 = exp_q.size();
    pop   = (size0 > 0) && rdy;
    push  = wr && (a == 8'hF4);
    if (pop) void'(exp_q.pop_front());
    if (push) begin
      if (size0 < DEPTH || pop) exp_q.push_back(d);
      else n_ovf = 1;
    end
    if (wr && a < 8'hF0) m_ram[a] = d;
    if (wr && a == 8'hF0) m_leds = d;
    if (wr && a == 8'hF2) m_cmp = d;
    m_match = n_match;
    m_ovf   = n_ovf;
  endtask

  // ---------------- driver tasks ----------------
  // One bus cycle: drive, check outputs mid-cycle, advance model and clock.
  task automatic step(input bit r, input logic [7:0] a, input bit rd, input bit wr,
                      input logic [7:0] d, input bit rdy);
    rst       = r;
    cpu_addr  = a;
    cpu_read  = rd;
    cpu_write = wr;
    cpu_dout  = d;
    tx_ready  = rdy;
    @(negedge clk);
    obs_din      = cpu_din;
    obs_tx_data  = tx_data;
    obs_tx_valid = tx_valid;
    obs_match    = timer_match;
    check("cpu_din", cpu_din, rd ? model_read(a) : 8'h00);
    check("leds", leds, m_leds);
    check("timer_match", timer_match, m_match);
    check("tx_valid", tx_valid, exp_q.size() != 0);
    if (exp_q.size() != 0) check("tx_data", tx_data, exp_q[0]);
    model_update(r, a, rd, wr, d, rdy);
    @(posedge clk);
    #1;
  endtask

  task automatic bus_wr(input logic [7:0] a, input logic [7:0] d);
    step(1'b0, a, 1'b0, 1'b1, d, cur_rdy);
  endtask

  task automatic bus_rd(input logic [7:0] a);
    step(1'b0, a, 1'b1, 1'b0, 8'h00, cur_rdy);
  endtask

  task automatic bus_idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, cur_rdy);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [7:0] a;
    logic [7:0] exp_pop [4];
    cur_rdy   = 1'b0;
    rst       = 1'b1;
    cpu_addr  = 8'h00;
    cpu_read  = 1'b0;
    cpu_write = 1'b0;
    cpu_dout  = 8'h00;
    tx_ready  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();

    // Reset state
    bus_rd(8'hF2);
    check("rst_cmp", obs_din, 8'hFF);
    bus_rd(8'hF3);
    check("rst_status", obs_din, 8'h04);
    check("rst_tx_valid", obs_tx_valid, 1'b0);

    // Fill the RAM with random bytes so every later read is defined
    for (int i = 0; i < 240; i++) bus_wr(8'(i), 8'($urandom_range(0, 255)));

    // RAM and decode
    bus_wr(8'h10, 8'h5A);
    bus_wr(8'hEF, 8'hA5);
    bus_rd(8'h10);
    check("ram_10", obs_din, 8'h5A);
    bus_rd(8'hEF);
    check("ram_ef", obs_din, 8'hA5);
    bus_rd(8'hF7);
    check("unmapped_f7", obs_din, 8'h00);
    check("leds_idle", leds, 8'h00);

    // LEDS and read+write collision
    bus_wr(8'hF0, 8'h3C);
    bus_idle(1);
    check("leds_3c", leds, 8'h3C);
    step(1'b0, 8'hF0, 1'b1, 1'b1, 8'h81, cur_rdy);
    check("leds_collision_din", obs_din, 8'h3C);
    bus_idle(1);
    check("leds_81", leds, 8'h81);

    // Timer and match
    bus_wr(8'hF2, 8'h03);
    bus_wr(8'hF1, 8'h00);
    bus_idle(12);
    bus_rd(8'hF1);
    check("timer_3", obs_din, 8'h03);
    check("match_set", obs_match, 1'b1);
    bus_rd(8'hF3);
    check("status_match", obs_din, 8'h05);
    bus_idle(1);
    check("match_cleared", obs_match, 1'b0);

    // Count wrap 0xFF -> 0x00
    bus_wr(8'hF2, 8'h10);
    bus_wr(8'hF1, 8'hFE);
    bus_idle(8);
    bus_rd(8'hF1);
    check("timer_wrap", obs_din, 8'h00);
    check("wrap_no_match", obs_match, 1'b0);

    // FIFO fill and overflow (timer parked far from CMP)
    bus_wr(8'hF2, 8'hFF);
    bus_wr(8'hF1, 8'h00);
    cur_rdy = 1'b0;
    bus_wr(8'hF4, 8'h11);
    bus_wr(8'hF4, 8'h22);
    bus_wr(8'hF4, 8'h33);
    bus_wr(8'hF4, 8'h44);
    bus_wr(8'hF4, 8'h55);
    bus_rd(8'hF3);
    check("status_full_ovf", obs_din, 8'h4A);
    cur_rdy = 1'b1;
    exp_pop = '{8'h11, 8'h22, 8'h33, 8'h44};
    for (int i = 0; i < 4; i++) begin
      bus_idle(1);
      check("pop_data", obs_tx_data, exp_pop[i]);
    end
    bus_rd(8'hF3);
    check("drained_valid", obs_tx_valid, 1'b0);
    check("status_empty", obs_din, 8'h04);

    // Full + simultaneous push/pop
    cur_rdy = 1'b0;
    bus_wr(8'hF4, 8'hAA);
    bus_wr(8'hF4, 8'hBB);
    bus_wr(8'hF4, 8'hCC);
    bus_wr(8'hF4, 8'hDD);
    step(1'b0, 8'hF4, 1'b0, 1'b1, 8'h99, 1'b1);
    check("pushpop_head", obs_tx_data, 8'hAA);
    bus_rd(8'hF3);
    check("status_full_no_ovf", obs_din, 8'h42);
    cur_rdy = 1'b1;
    exp_pop = '{8'hBB, 8'hCC, 8'hDD, 8'h99};
    for (int i = 0; i < 4; i++) begin
      bus_idle(1);
      check("pushpop_data", obs_tx_data, exp_pop[i]);
    end
    bus_idle(1);
    check("pushpop_drained", obs_tx_valid, 1'b0);

    // Reset mid-operation
    cur_rdy = 1'b0;
    bus_wr(8'hF4, 8'h01);
    bus_wr(8'hF4, 8'h02);
    bus_wr(8'hF0, 8'h77);
    step(1'b1, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1);
    bus_rd(8'hF1);
    check("rst_mid_valid", obs_tx_valid, 1'b0);
    check("rst_mid_leds", leds, 8'h00);
    check("rst_mid_timer", obs_din, 8'h00);
    bus_rd(8'hF3);
    check("rst_mid_status", obs_din, 8'h04);
    bus_rd(8'hF2);
    check("rst_mid_cmp", obs_din, 8'hFF);
    bus_rd(8'h10);
    check("rst_mid_ram", obs_din, 8'h5A);

    // Randomized traffic, checked every cycle against the model
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 3) == 0) a = 8'($urandom_range(0, 239));
      else a = 8'($urandom_range(240, 255));
      step($urandom_range(0, 199) == 0, a, 1'($urandom_range(0, 1)),
           $urandom_range(0, 2) == 0, 8'($urandom_range(0, 255)),
           1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
